sequenciador_operandos: RTL and testbench
=========================================

SEQUENCIADOR_OPERANDOS -- requirements
Module: sequenciador_operandos

Interface
REQ-001 Parameter: DEBOUNCE_CICLOS, 4, consecutive high samples of carregar required before a press is accepted; used only when DEBOUNCE_EN is defined; range 2..255.
REQ-002 Port: clk  input  1  the block's single clock; all state updates on its rising edge.
REQ-003 Port: reset  input  1  synchronous, active-high reset, sampled on the rising edge of clk.
REQ-004 Port: dados  input  8  switch value offered as operand A, operand B or opcode.
REQ-005 Port: carregar  input  1  load button (level); its rising edge advances the sequence.
REQ-006 Port: resultado_ula  input  8  combinational ALU result computed from op_a, op_b and opcode.
REQ-007 Port: flags_ula  input  4  combinational ALU flags {Z,N,C,V}.
REQ-008 Port: op_a  output  8  registered operand A.
REQ-009 Port: op_b  output  8  registered operand B.
REQ-010 Port: opcode  output  3  registered operation select (dados[2:0]).
REQ-011 Port: resultado  output  8  registered result.
REQ-012 Port: flags  output  4  registered flags.
REQ-013 Port: estado  output  3  current FSM state code.
REQ-014 Port: valido  output  1  high while resultado/flags are valid.

Function
REQ-015 carregar SHALL pass through one synchronising flop (carregar_s); a previous-sample flop (carregar_p) SHALL hold the prior value; press pulse = carregar_s AND NOT carregar_p, one cycle wide.
REQ-016 FSM states/codes: ESPERA_A=0, ESPERA_B=1, ESPERA_OP=2, CALCULA=3, EXIBE=4; codes 5-7 SHALL go to ESPERA_A on the next edge.
REQ-017 ESPERA_A + pulse: op_a <= dados, next ESPERA_B; without a pulse the state and registers SHALL hold.
REQ-018 ESPERA_B + pulse: op_b <= dados, next ESPERA_OP.
REQ-019 ESPERA_OP + pulse: opcode <= dados[2:0], next CALCULA.
REQ-020 CALCULA lasts exactly one cycle, unconditionally: resultado <= resultado_ula, flags <= flags_ula, next EXIBE.
REQ-021 A pulse arriving in CALCULA SHALL be ignored.
REQ-022 valido SHALL equal (estado == EXIBE), decoded from the state register with no combinational path from inputs.
REQ-023 EXIBE + pulse: valido falls, next ESPERA_A; op_a, op_b, opcode and resultado SHALL hold until overwritten.
REQ-024 Latency: carregar rising before clock edge E0 SHALL produce the register load and state change at edge E1 (2 edges).
REQ-025 Latency: result visible 1 edge after entering CALCULA.
REQ-026 Holding carregar high SHALL produce exactly one pulse; a new press requires carregar low for at least one sample.
REQ-027 dados SHALL be sampled only at the pulse edge; later dados changes SHALL not affect stored values.

Reset
REQ-028 reset high at a clk edge: estado=ESPERA_A, op_a=op_b=0, opcode=0, resultado=0, flags=0, valido=0, carregar_s=carregar_p=0, debounce counter=0.
REQ-029 Reset SHALL take priority over any simultaneous pulse, in any state including CALCULA.
REQ-030 If carregar is still high when reset deasserts, no pulse SHALL occur until carregar returns low and rises again.

Configuration
REQ-031 Macro DEBOUNCE_EN defined: a pulse SHALL be generated only after carregar_s has been high for DEBOUNCE_CICLOS consecutive cycles.
REQ-032 DEBOUNCE_EN defined: any low sample SHALL clear the counter; one pulse per stable high period; latency becomes DEBOUNCE_CICLOS+1 edges.
REQ-033 Macro DEBOUNCE_EN not defined: the counter SHALL be absent and REQ-015 edge detection applies directly.

Verification
REQ-034 Reset, then three presses with dados=0x25, 0x1A, 0x01, ALU model A+B -> op_a=0x25, op_b=0x1A, opcode=1; resultado=0x3F, flags=0000, valido=1 one edge after CALCULA.
REQ-035 Hold carregar high for 20 cycles in ESPERA_A -> exactly one state advance; estado=1.
REQ-036 Assert reset during CALCULA with a pulse pending -> all outputs 0, estado=0, valido=0 at the next edge.
REQ-037 In EXIBE change dados to 0xFF without a press -> op_a, op_b and resultado unchanged; a press -> estado=0, valido=0.
REQ-038 DEBOUNCE_EN with DEBOUNCE_CICLOS=4, carregar pattern 1,1,0,1,1,1,1 -> exactly one pulse, after the 4th consecutive high sample.
REQ-039 Force the state register to 6 -> estado=0 on the next edge.

Source files
------------

// File: rtl/sequenciador_operandos_if.sv
// Operand sequencer bus: switch/button inputs, ALU feedback and the
// registered operands, result and status returned by the sequencer.
interface sequenciador_operandos_if;
  logic [7:0] dados;
  logic       carregar;
  logic [7:0] resultado_ula;
  logic [3:0] flags_ula;
  logic [7:0] op_a;
  logic [7:0] op_b;
  logic [2:0] opcode;
  logic [7:0] resultado;
  logic [3:0] flags;
  logic [2:0] estado;
  logic       valido;

  // Environment side: drives switches, button and ALU results.
  modport master (
    output dados, carregar, resultado_ula, flags_ula,
    input  op_a, op_b, opcode, resultado, flags, estado, valido
  );

  // Sequencer side.
  modport slave (
    input  dados, carregar, resultado_ula, flags_ula,
    output op_a, op_b, opcode, resultado, flags, estado, valido
  );
endinterface

// File: rtl/sequenciador_operandos.sv
// Operand sequencer: collects operand A, operand B and an opcode from the
// switches on successive presses of the load button, captures the ALU
// result for one cycle and then displays it until the next press.
// Optional macro DEBOUNCE_EN: a press is accepted only after the
// synchronised button has been high for DEBOUNCE_CICLOS consecutive cycles.
module sequenciador_operandos #(
  parameter int DEBOUNCE_CICLOS = 4
) (
  input logic                     clk,
  input logic                     reset,
  sequenciador_operandos_if.slave bus
);

  localparam logic [2:0] ESPERA_A  = 3'd0;
  localparam logic [2:0] ESPERA_B  = 3'd1;
  localparam logic [2:0] ESPERA_OP = 3'd2;
  localparam logic [2:0] CALCULA   = 3'd3;
  localparam logic [2:0] EXIBE     = 3'd4;

  logic [2:0] estado_q;
  logic [2:0] estado_d;

  logic       carregar_s;
  logic       carregar_p;
  logic       amostra_real;
  logic       armado;
  logic       pulso;

  logic       carga_a;
  logic       carga_b;
  logic       carga_op;
  logic       carga_res;
  logic       valido;

  logic [7:0] op_a_q;
  logic [7:0] op_b_q;
  logic [2:0] opcode_q;
  logic [7:0] resultado_q;
  logic [3:0] flags_q;

  // Button synchroniser and previous sample. amostra_real marks that
  // carregar_s holds a genuine sample (not the reset value); armado is set
  // once a real low sample has been seen, so a button still held through
  // reset cannot produce a press.
  always_ff @(posedge clk) begin
    if (reset) begin
      carregar_s   <= 1'b0;
      carregar_p   <= 1'b0;
      amostra_real <= 1'b0;
      armado       <= 1'b0;
    end else begin
      carregar_s   <= bus.carregar;
      carregar_p   <= carregar_s;
      amostra_real <= 1'b1;
      if (amostra_real && !carregar_s) armado <= 1'b1;
    end
  end

`ifdef DEBOUNCE_EN
  localparam logic [7:0] LIMITE = 8'(DEBOUNCE_CICLOS);

  logic [7:0] cont_deb;

  // Consecutive-high counter; saturates so a long hold gives one press.
  always_ff @(posedge clk) begin
    if (reset) begin
      cont_deb <= 8'd0;
    end else if (!carregar_s) begin
      cont_deb <= 8'd0;
    end else if (cont_deb != LIMITE) begin
      cont_deb <= cont_deb + 8'd1;
    end
  end

  // Press fires on the DEBOUNCE_CICLOS-th consecutive high sample.
  always_comb begin
    pulso = armado && carregar_s && (cont_deb == (LIMITE - 8'd1));
  end
`else
  // Press is the rising edge of the synchronised button.
  always_comb begin
    pulso = armado && carregar_s && !carregar_p;
  end
`endif

  // State register.
  always_ff @(posedge clk) begin
    if (reset) estado_q <= ESPERA_A;
    else       estado_q <= estado_d;
  end

  // Next-state logic; CALCULA is a single unconditional cycle and unused
  // codes fall back to ESPERA_A.
  always_comb begin
    estado_d = estado_q;
    case (estado_q)
      ESPERA_A:  if (pulso) estado_d = ESPERA_B;
      ESPERA_B:  if (pulso) estado_d = ESPERA_OP;
      ESPERA_OP: if (pulso) estado_d = CALCULA;
      CALCULA:   estado_d = EXIBE;
      EXIBE:     if (pulso) estado_d = ESPERA_A;
      default:   estado_d = ESPERA_A;
    endcase
  end

  // Output decode: register load enables and valid, from state and press.
  always_comb begin
    carga_a   = 1'b0;
    carga_b   = 1'b0;
    carga_op  = 1'b0;
    carga_res = 1'b0;
    valido    = 1'b0;
    case (estado_q)
      ESPERA_A:  carga_a   = pulso;
      ESPERA_B:  carga_b   = pulso;
      ESPERA_OP: carga_op  = pulso;
      CALCULA:   carga_res = 1'b1;
      EXIBE:     valido    = 1'b1;
      default:   valido    = 1'b0;
    endcase
  end

  // Operand, opcode and result registers; each holds until reloaded.
  always_ff @(posedge clk) begin
    if (reset) begin
      op_a_q      <= 8'd0;
      op_b_q      <= 8'd0;
      opcode_q    <= 3'd0;
      resultado_q <= 8'd0;
      flags_q     <= 4'd0;
    end else begin
      if (carga_a)  op_a_q   <= bus.dados;
      if (carga_b)  op_b_q   <= bus.dados;
      if (carga_op) opcode_q <= bus.dados[2:0];
      if (carga_res) begin
        resultado_q <= bus.resultado_ula;
        flags_q     <= bus.flags_ula;
      end
    end
  end

  assign bus.op_a      = op_a_q;
  assign bus.op_b      = op_b_q;
  assign bus.opcode    = opcode_q;
  assign bus.resultado = resultado_q;
  assign bus.flags     = flags_q;
  assign bus.estado    = estado_q;
  assign bus.valido    = valido;

endmodule

// File: tb/tb_sequenciador_operandos.sv
// Bench for sequenciador_operandos: cycle-level vector table with a
// scoreboard queue, an adder ALU model, and a forced illegal-state check.
module tb_sequenciador_operandos;

  logic clk;
  logic reset;

  sequenciador_operandos_if bus ();

  sequenciador_operandos #(.DEBOUNCE_CICLOS(4)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ALU model: A+B with {Z,N,C,V}.
  logic [8:0] soma;
  assign soma = {1'b0, bus.op_a} + {1'b0, bus.op_b};
  assign bus.resultado_ula = soma[7:0];
  assign bus.flags_ula = {(soma[7:0] == 8'd0), soma[7], soma[8],
                          (bus.op_a[7] == bus.op_b[7]) && (soma[7] != bus.op_a[7])};

  typedef struct {
    logic       rst;
    logic       car;
    logic [7:0] d;
    logic [2:0] st;
    logic [7:0] a;
    logic [7:0] b;
    logic [2:0] op;
    logic [7:0] res;
    logic [3:0] flg;
    logic       val;
  } vec_t;

  vec_t tbl[$];
  vec_t exp_q[$];

  int n_tests = 0;
  int n_fail  = 0;

  task automatic row(input logic rst, input logic car, input logic [7:0] d,
                     input logic [2:0] st, input logic [7:0] a, input logic [7:0] b,
                     input logic [2:0] op, input logic [7:0] res,
                     input logic [3:0] flg, input logic val);
    vec_t v;
    v.rst = rst; v.car = car; v.d = d; v.st = st; v.a = a; v.b = b;
    v.op = op; v.res = res; v.flg = flg; v.val = val;
    tbl.push_back(v);
  endtask

  task automatic check(input string nome, input logic [34:0] got, input logic [34:0] req);
    n_tests++;
    if (got !== req) begin
      n_fail++;
      $display("FAIL %s: got st/a/b/op/res/flg/val=%h required %h", nome, got, req);
    end
  endtask

  initial begin
    vec_t e;
    logic [34:0] got;
    logic [34:0] req;

    reset = 1'b1;
    bus.carregar = 1'b0;
    bus.dados = 8'h00;

`ifdef DEBOUNCE_EN
    row(1,0,8'h00, 0,8'h00,8'h00,0,8'h00,4'h0,0);
    row(0,0,8'hAA, 0,8'h00,8'h00,0,8'h00,4'h0,0);
    row(0,0,8'hAA, 0,8'h00,8'h00,0,8'h00,4'h0,0);
    row(0,1,8'hAA, 0,8'h00,8'h00,0,8'h00,4'h0,0);
    row(0,1,8'hAA, 0,8'h00,8'h00,0,8'h00,4'h0,0);
    row(0,0,8'hAA, 0,8'h00,8'h00,0,8'h00,4'h0,0);
    for (int k = 0; k < 4; k++) row(0,1,8'hAA, 0,8'h00,8'h00,0,8'h00,4'h0,0);
    row(0,1,8'hAA, 1,8'hAA,8'h00,0,8'h00,4'h0,0);
    for (int k = 0; k < 6; k++) row(0,1,8'hBB, 1,8'hAA,8'h00,0,8'h00,4'h0,0);
`else
    // Reset, then A=0x25, B=0x1A, opcode=1 -> 0x3F, flags 0000.
    row(1,0,8'h00, 0,8'h00,8'h00,0,8'h00,4'h0,0);
    row(0,0,8'h25, 0,8'h00,8'h00,0,8'h00,4'h0,0);
    row(0,1,8'h25, 0,8'h00,8'h00,0,8'h00,4'h0,0);
    row(0,1,8'h25, 1,8'h25,8'h00,0,8'h00,4'h0,0);
    row(0,0,8'h1A, 1,8'h25,8'h00,0,8'h00,4'h0,0);
    row(0,1,8'h1A, 1,8'h25,8'h00,0,8'h00,4'h0,0);
    row(0,1,8'h1A, 2,8'h25,8'h1A,0,8'h00,4'h0,0);
    row(0,0,8'h01, 2,8'h25,8'h1A,0,8'h00,4'h0,0);
    row(0,1,8'h01, 2,8'h25,8'h1A,0,8'h00,4'h0,0);
    row(0,0,8'h01, 3,8'h25,8'h1A,1,8'h00,4'h0,0);
    row(0,0,8'h01, 4,8'h25,8'h1A,1,8'h3F,4'h0,1);
    // EXIBE: dados to 0xFF with no press, then a press.
    row(0,0,8'hFF, 4,8'h25,8'h1A,1,8'h3F,4'h0,1);
    row(0,1,8'hFF, 4,8'h25,8'h1A,1,8'h3F,4'h0,1);
    row(0,0,8'hFF, 0,8'h25,8'h1A,1,8'h3F,4'h0,0);
    // 0x80 + 0x80: wraps to zero with Z, C and V set.
    row(0,1,8'h80, 0,8'h25,8'h1A,1,8'h3F,4'h0,0);
    row(0,0,8'h80, 1,8'h80,8'h1A,1,8'h3F,4'h0,0);
    row(0,1,8'h80, 1,8'h80,8'h1A,1,8'h3F,4'h0,0);
    row(0,0,8'h80, 2,8'h80,8'h80,1,8'h3F,4'h0,0);
    row(0,1,8'h07, 2,8'h80,8'h80,1,8'h3F,4'h0,0);
    row(0,0,8'h07, 3,8'h80,8'h80,7,8'h3F,4'h0,0);
    row(0,1,8'h00, 4,8'h80,8'h80,7,8'h00,4'hB,1);
    row(0,1,8'h00, 0,8'h80,8'h80,7,8'h00,4'hB,0);
    // Button held high for 21 samples: one advance only.
    row(0,0,8'h55, 0,8'h80,8'h80,7,8'h00,4'hB,0);
    row(0,1,8'h55, 0,8'h80,8'h80,7,8'h00,4'hB,0);
    for (int k = 0; k < 20; k++) row(0,1,8'h55, 1,8'h55,8'h80,7,8'h00,4'hB,0);
    // Reach CALCULA, then reset there with the button high.
    row(0,0,8'h66, 1,8'h55,8'h80,7,8'h00,4'hB,0);
    row(0,1,8'h66, 1,8'h55,8'h80,7,8'h00,4'hB,0);
    row(0,0,8'h66, 2,8'h55,8'h66,7,8'h00,4'hB,0);
    row(0,1,8'h66, 2,8'h55,8'h66,7,8'h00,4'hB,0);
    row(0,0,8'h66, 3,8'h55,8'h66,6,8'h00,4'hB,0);
    row(1,1,8'h66, 0,8'h00,8'h00,0,8'h00,4'h0,0);
    // Button still high out of reset: no press until it falls and rises.
    row(0,1,8'h12, 0,8'h00,8'h00,0,8'h00,4'h0,0);
    row(0,1,8'h12, 0,8'h00,8'h00,0,8'h00,4'h0,0);
    row(0,0,8'h12, 0,8'h00,8'h00,0,8'h00,4'h0,0);
    row(0,1,8'h12, 0,8'h00,8'h00,0,8'h00,4'h0,0);
    row(0,0,8'h12, 1,8'h12,8'h00,0,8'h00,4'h0,0);
`endif

    for (int i = 0; i < tbl.size(); i++) begin
      @(negedge clk);
      reset        = tbl[i].rst;
      bus.carregar = tbl[i].car;
      bus.dados    = tbl[i].d;
      exp_q.push_back(tbl[i]);
      @(posedge clk);
      #1;
      e   = exp_q.pop_front();
      got = {bus.estado, bus.op_a, bus.op_b, bus.opcode, bus.resultado, bus.flags, bus.valido};
      req = {e.st, e.a, e.b, e.op, e.res, e.flg, e.val};
      check($sformatf("vec%0d", i), got, req);
    end

    // Illegal state code 6 returns to ESPERA_A on the next edge.
    @(negedge clk);
    bus.carregar = 1'b0;
    force dut.estado_q = 3'd6;
    #1;
    release dut.estado_q;
    #1;
    n_tests++;
    if (bus.estado !== 3'd6) begin
      n_fail++;
      $display("FAIL forced_state: got %0d required 6", bus.estado);
    end
    @(posedge clk);
    #1;
    n_tests++;
    if (bus.estado !== 3'd0 || bus.valido !== 1'b0) begin
      n_fail++;
      $display("FAIL illegal_recover: got estado=%0d valido=%b required 0/0",
               bus.estado, bus.valido);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
